// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline stage with wait-stated local data RAM and register write-back
module mem_wb_stage #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MEM_Valid,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [4:0]  EX_MEM_Rd,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_MemToReg,
  input  logic        EX_MEM_RegWrite,
  output logic        Stall,
  output logic        MemFault,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_writeReg,
  output logic [31:0] WB_writeData
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        req_store;
  logic        req_m2r;
  logic        req_rw;

  logic [31:0] ram [0:(2**ADDR_W)-1];

  logic              mem_op;
  logic              complete;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [4:0]        sel_rd;
  logic              sel_store;
  logic              sel_m2r;
  logic              sel_rw;
  logic              sel_fault;
  logic [ADDR_W-1:0] sel_word;
  logic [31:0]       load_val;

  assign mem_op = EX_MEM_Valid & (EX_MEM_MemRead | EX_MEM_MemWrite);

  // While BUSY the live inputs are ignored; the access uses the request latched at entry.
  always_comb begin
    sel_addr  = EX_MEM_ALUResult;
    sel_wdata = EX_MEM_WriteData;
    sel_rd    = EX_MEM_Rd;
    sel_store = EX_MEM_MemWrite;
    sel_m2r   = EX_MEM_MemToReg;
    sel_rw    = EX_MEM_RegWrite;
    if (state == BUSY) begin
      sel_addr  = req_addr;
      sel_wdata = req_wdata;
      sel_rd    = req_rd;
      sel_store = req_store;
      sel_m2r   = req_m2r;
      sel_rw    = req_rw;
    end
  end

  assign sel_word  = sel_addr[ADDR_W+1:2];
  assign sel_fault = (|sel_addr[1:0]) | (|sel_addr[31:ADDR_W+2]);
  assign load_val  = ram[sel_word];

  assign complete = rst & ((state == BUSY) ? (cnt == 4'd0)
                                           : (mem_op && (MEM_LATENCY == 0)));
  assign Stall    = rst & (((state == IDLE) && mem_op && (MEM_LATENCY != 0)) ||
                           ((state == BUSY) && (cnt != 4'd0)));

  // RAM is deliberately outside the reset domain; rst gates writes so a reset mid-access drops them.
  always_ff @(posedge clk) begin
    if (complete && sel_store && !sel_fault) begin
      ram[sel_word] <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      req_addr     <= 32'd0;
      req_wdata    <= 32'd0;
      req_rd       <= 5'd0;
      req_store    <= 1'b0;
      req_m2r      <= 1'b0;
      req_rw       <= 1'b0;
      MemFault     <= 1'b0;
      WB_RegWrite  <= 1'b0;
      WB_writeReg  <= 5'd0;
      WB_writeData <= 32'd0;
    end else begin
      MemFault <= 1'b0;
      if (complete) begin
        state       <= IDLE;
        MemFault    <= sel_fault;
        WB_writeReg <= sel_rd;
        if (sel_store) begin
          WB_RegWrite <= 1'b0;
        end else begin
          WB_RegWrite  <= sel_rw & (sel_rd != 5'd0);
          WB_writeData <= sel_m2r ? (sel_fault ? 32'd0 : load_val) : sel_addr;
        end
      end else if ((state == IDLE) && mem_op) begin
        state       <= BUSY;
        cnt         <= 4'(MEM_LATENCY - 1);
        req_addr    <= EX_MEM_ALUResult;
        req_wdata   <= EX_MEM_WriteData;
        req_rd      <= EX_MEM_Rd;
        req_store   <= EX_MEM_MemWrite;
        req_m2r     <= EX_MEM_MemToReg;
        req_rw      <= EX_MEM_RegWrite;
        WB_RegWrite <= 1'b0;
      end else if (state == BUSY) begin
        cnt         <= cnt - 4'd1;
        WB_RegWrite <= 1'b0;
      end else begin
        WB_RegWrite  <= EX_MEM_Valid & EX_MEM_RegWrite & (EX_MEM_Rd != 5'd0);
        WB_writeReg  <= EX_MEM_Rd;
        WB_writeData <= EX_MEM_ALUResult;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed bench for mem_wb_stage (MEM_LATENCY=2 and MEM_LATENCY=0 instances)
module tb_mem_wb_stage;

  logic clk;
  logic rst;

  logic        a_valid, a_mr, a_mw, a_m2r, a_rw;
  logic [31:0] a_alu, a_wd;
  logic [4:0]  a_rd;
  logic        a_stall, a_fault, a_wb_rw;
  logic [4:0]  a_wb_reg;
  logic [31:0] a_wb_data;

  logic        b_valid, b_mr, b_mw, b_m2r, b_rw;
  logic [31:0] b_alu, b_wd;
  logic [4:0]  b_rd;
  logic        b_stall, b_fault, b_wb_rw;
  logic [4:0]  b_wb_reg;
  logic [31:0] b_wb_data;

  int n_vec = 0;
  int n_bad = 0;
  int st;

  mem_wb_stage #(.ADDR_W(8), .MEM_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .EX_MEM_Valid(a_valid), .EX_MEM_ALUResult(a_alu), .EX_MEM_WriteData(a_wd),
    .EX_MEM_Rd(a_rd), .EX_MEM_MemRead(a_mr), .EX_MEM_MemWrite(a_mw),
    .EX_MEM_MemToReg(a_m2r), .EX_MEM_RegWrite(a_rw),
    .Stall(a_stall), .MemFault(a_fault), .WB_RegWrite(a_wb_rw),
    .WB_writeReg(a_wb_reg), .WB_writeData(a_wb_data)
  );

  mem_wb_stage #(.ADDR_W(8), .MEM_LATENCY(0)) dut_b (
    .clk(clk), .rst(rst),
    .EX_MEM_Valid(b_valid), .EX_MEM_ALUResult(b_alu), .EX_MEM_WriteData(b_wd),
    .EX_MEM_Rd(b_rd), .EX_MEM_MemRead(b_mr), .EX_MEM_MemWrite(b_mw),
    .EX_MEM_MemToReg(b_m2r), .EX_MEM_RegWrite(b_rw),
    .Stall(b_stall), .MemFault(b_fault), .WB_RegWrite(b_wb_rw),
    .WB_writeReg(b_wb_reg), .WB_writeData(b_wb_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic mr, input logic mw,
                       input logic m2r, input logic rw);
    a_valid = v; a_alu = alu; a_wd = wd; a_rd = rd;
    a_mr = mr; a_mw = mw; a_m2r = m2r; a_rw = rw;
  endtask

  task automatic set_b(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic mr, input logic mw,
                       input logic m2r, input logic rw);
    b_valid = v; b_alu = alu; b_wd = wd; b_rd = rd;
    b_mr = mr; b_mw = mw; b_m2r = m2r; b_rw = rw;
  endtask

  // Hold the op until Stall drops, then take the completion edge; returns stalled cycles.
  task automatic run_a(output int stalls);
    stalls = 0;
    #1;
    while (a_stall === 1'b1 && stalls < 20) begin
      step();
      stalls++;
    end
    step();
  endtask

  initial begin
    rst = 1'b0;
    set_a(1, 32'h10, 32'h0, 5'd1, 1, 0, 1, 1);
    set_b(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    repeat (3) step();

    // T1 reset with LW pending at inputs
    chk("t1_stall", a_stall, 0);
    chk("t1_wb_rw", a_wb_rw, 0);
    chk("t1_wb_reg", a_wb_reg, 0);
    chk("t1_wb_data", a_wb_data, 0);
    chk("t1_fault", a_fault, 0);
    chk("t1_b_stall", b_stall, 0);
    rst = 1'b1;
    #1;
    chk("t1_start_stall", a_stall, 1);
    run_a(st);
    chk("t1_stall_cycles", st, 2);
    chk("t1_wb_rw_done", a_wb_rw, 1);
    chk("t1_wb_reg_done", a_wb_reg, 1);

    // T2 ALU op
    set_a(1, 32'h2A, 32'h0, 5'd5, 0, 0, 0, 1);
    #1;
    chk("t2_stall", a_stall, 0);
    step();
    chk("t2_wb_rw", a_wb_rw, 1);
    chk("t2_wb_reg", a_wb_reg, 5);
    chk("t2_wb_data", a_wb_data, 32'h2A);

    // write to r0 suppressed, address/data still update
    set_a(1, 32'h77, 32'h0, 5'd0, 0, 0, 0, 1);
    step();
    chk("r0_wb_rw", a_wb_rw, 0);
    chk("r0_wb_reg", a_wb_reg, 0);
    chk("r0_wb_data", a_wb_data, 32'h77);

    // T3 SW then LW, same word
    set_a(1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0);
    run_a(st);
    chk("t3_sw_stalls", st, 2);
    chk("t3_sw_wb_rw", a_wb_rw, 0);
    set_a(1, 32'h10, 32'h0, 5'd3, 1, 0, 1, 1);
    run_a(st);
    chk("t3_lw_stalls", st, 2);
    chk("t3_lw_wb_rw", a_wb_rw, 1);
    chk("t3_lw_wb_reg", a_wb_reg, 3);
    chk("t3_lw_wb_data", a_wb_data, 32'hDEADBEEF);
    chk("t3_lw_fault", a_fault, 0);

    // T4 faults: store to out-of-range alias of word 0 dropped; misaligned/out-of-range loads
    set_a(1, 32'h0, 32'h11111111, 5'd0, 0, 1, 0, 0);
    run_a(st);
    set_a(1, 32'h400, 32'h00000BAD, 5'd0, 0, 1, 0, 0);
    run_a(st);
    chk("t4_sw_fault", a_fault, 1);
    set_a(0, 32'h5555, 32'h0, 5'd0, 0, 0, 0, 0);
    step();
    chk("t4_fault_pulse_end", a_fault, 0);
    set_a(1, 32'h13, 32'h0, 5'd4, 1, 0, 1, 1);
    run_a(st);
    chk("t4_mis_fault", a_fault, 1);
    chk("t4_mis_data", a_wb_data, 0);
    chk("t4_mis_reg", a_wb_reg, 4);
    set_a(0, 32'h5555, 32'h0, 5'd0, 0, 0, 0, 0);
    step();
    chk("t4_bubble_data", a_wb_data, 32'h5555);
    set_a(1, 32'h400, 32'h0, 5'd4, 1, 0, 1, 1);
    run_a(st);
    chk("t4_oor_fault", a_fault, 1);
    chk("t4_oor_data", a_wb_data, 0);
    set_a(1, 32'h0, 32'h0, 5'd6, 1, 0, 1, 1);
    run_a(st);
    chk("t4_word0_data", a_wb_data, 32'h11111111);
    chk("t4_word0_fault", a_fault, 0);

    // T5 reset mid-BUSY on a store
    set_a(1, 32'h0, 32'h22222222, 5'd0, 0, 1, 0, 0);
    #1;
    chk("t5_stall_pre", a_stall, 1);
    step();
    rst = 1'b0;
    #1;
    chk("t5_stall_rst", a_stall, 0);
    chk("t5_wb_rw_rst", a_wb_rw, 0);
    chk("t5_wb_data_rst", a_wb_data, 0);
    step();
    step();
    set_a(1, 32'h0, 32'h0, 5'd6, 1, 0, 1, 1);
    rst = 1'b1;
    run_a(st);
    chk("t5_lw_stalls", st, 2);
    chk("t5_lw_wb_rw", a_wb_rw, 1);
    chk("t5_lw_wb_reg", a_wb_reg, 6);
    chk("t5_lw_data", a_wb_data, 32'h11111111);

    // T6 zero-latency instance streams one op per cycle
    set_b(1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0);
    #1;
    chk("t6_sw_stall", b_stall, 0);
    step();
    chk("t6_sw_wb_rw", b_wb_rw, 0);
    set_b(1, 32'h10, 32'h0, 5'd3, 1, 0, 1, 1);
    #1;
    chk("t6_lw_stall", b_stall, 0);
    step();
    chk("t6_lw_wb_rw", b_wb_rw, 1);
    chk("t6_lw_wb_reg", b_wb_reg, 3);
    chk("t6_lw_wb_data", b_wb_data, 32'hDEADBEEF);
    set_b(1, 32'h2A, 32'h0, 5'd5, 0, 0, 0, 1);
    #1;
    chk("t6_alu_stall", b_stall, 0);
    step();
    chk("t6_alu_wb_reg", b_wb_reg, 5);
    chk("t6_alu_wb_data", b_wb_data, 32'h2A);
    set_b(1, 32'h13, 32'h0, 5'd4, 1, 0, 1, 1);
    step();
    chk("t6_mis_fault", b_fault, 1);
    chk("t6_mis_data", b_wb_data, 0);
    set_b(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    step();
    chk("t6_fault_end", b_fault, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
